// File: rtl/serial_adder.sv
// serial_adder: bit-serial, LSB-first adder. One bit of each operand is
// accepted per valid beat, the running sum bit is emitted one cycle later,
// and after WIDTH accepted beats the full sum word and final carry are
// presented with a one-cycle word_valid pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' port; with sub=1
// latched on the first beat, B is inverted and the initial carry is 1, so
// the block computes A-B modulo 2^WIDTH (carry_out=1 means no borrow).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_first,
   input  logic             a_bit,
   input  logic             b_bit,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             sum_bit,
   output logic             sum_bit_valid,
   output logic [WIDTH-1:0] sum_word,
   output logic             carry_out,
   output logic             word_valid,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [0:0]    ST_IDLE  = 1'b0;
   localparam logic [0:0]    ST_ACCUM = 1'b1;
   localparam logic [CW-1:0] LAST_C   = CW'(WIDTH);

   // Full-adder carry: majority of the three inputs.
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   logic [0:0]       state_r;
   logic [CW-1:0]    count_r;
   logic             carry_r;
   logic [WIDTH-1:0] word_r;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub_r;
`endif

   logic             start_s;
   logic             cont_s;
   logic             take_s;
   logic             sub_s;
   logic             b_eff_s;
   logic             c_in_s;
   logic             s_s;
   logic             c_out_s;
   logic [CW-1:0]    pos_s;
   logic [CW-1:0]    count_next_s;
   logic             done_s;
   logic [WIDTH-1:0] word_base_s;
   logic [WIDTH-1:0] word_next_s;

   // Beat acceptance, one full-adder step and the next partial-word value.
   always_comb begin
      start_s = in_valid & in_first;
      cont_s  = in_valid & ~in_first & (state_r == ST_ACCUM);
      take_s  = start_s | cont_s;
`ifdef SERIAL_ADDER_SUB_EN
      if (start_s) begin
         sub_s = sub;
      end else begin
         sub_s = sub_r;
      end
`else
      sub_s = 1'b0;
`endif
      b_eff_s = b_bit ^ sub_s;
      // A first beat (also a restart) starts from c0 and a cleared word.
      if (start_s) begin
         c_in_s      = sub_s;
         pos_s       = {CW{1'b0}};
         word_base_s = {WIDTH{1'b0}};
      end else begin
         c_in_s      = carry_r;
         pos_s       = count_r;
         word_base_s = word_r;
      end
      s_s          = a_bit ^ b_eff_s ^ c_in_s;
      c_out_s      = maj3(a_bit, b_eff_s, c_in_s);
      count_next_s = pos_s + CW'(1);
      done_s       = take_s & (count_next_s == LAST_C);
      word_next_s  = word_base_s;
      for (int i = 0; i < WIDTH; i++) begin
         if (pos_s == CW'(i)) begin
            word_next_s[i] = s_s;
         end else begin
            word_next_s[i] = word_base_s[i];
         end
      end
   end

   // Word-accumulation state: FSM, bit count, carry chain and partial sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         count_r <= {CW{1'b0}};
         carry_r <= 1'b0;
         word_r  <= {WIDTH{1'b0}};
`ifdef SERIAL_ADDER_SUB_EN
         sub_r   <= 1'b0;
`endif
      end else if (take_s) begin
         word_r <= word_next_s;
`ifdef SERIAL_ADDER_SUB_EN
         sub_r  <= sub_s;
`endif
         if (done_s) begin
            state_r <= ST_IDLE;
            count_r <= {CW{1'b0}};
            carry_r <= 1'b0;
         end else begin
            state_r <= ST_ACCUM;
            count_r <= count_next_s;
            carry_r <= c_out_s;
         end
      end
   end

   // Registered outputs: per-beat sum bit and completed-word capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_bit       <= 1'b0;
         sum_bit_valid <= 1'b0;
         sum_word      <= {WIDTH{1'b0}};
         carry_out     <= 1'b0;
         word_valid    <= 1'b0;
      end else begin
         sum_bit_valid <= take_s;
         word_valid    <= done_s;
         if (take_s) begin
            sum_bit <= s_s;
         end
         if (done_s) begin
            sum_word  <= word_next_s;
            carry_out <= c_out_s;
         end
      end
   end

   assign busy = (state_r == ST_ACCUM);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed, table-driven checks of serial_adder (WIDTH=8)
// plus hand-written sequences for latency, back-to-back words, stalls,
// restart, asynchronous reset and ignored non-first beats in IDLE.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_first;
   logic         a_bit;
   logic         b_bit;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub;
`endif
   logic         sum_bit;
   logic         sum_bit_valid;
   logic [W-1:0] sum_word;
   logic         carry_out;
   logic         word_valid;
   logic         busy;

   serial_adder #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_first      (in_first),
      .a_bit         (a_bit),
      .b_bit         (b_bit),
`ifdef SERIAL_ADDER_SUB_EN
      .sub           (sub),
`endif
      .sum_bit       (sum_bit),
      .sum_bit_valid (sum_bit_valid),
      .sum_word      (sum_word),
      .carry_out     (carry_out),
      .word_valid    (word_valid),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_sum;
      logic         exp_c;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Event log filled by the monitor; tests compare against deltas.
   int           nbits  = 0;
   int           nwords = 0;
   logic         bits_arr  [0:1023];
   logic [W-1:0] wword_arr [0:127];
   logic         wcarry_arr[0:127];
   int           wcyc_arr  [0:127];

   // Cycle counter used for word_valid spacing.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: log every sum_bit pulse and every completed word.
   always @(negedge clk) begin
      if (sum_bit_valid && nbits < 1024) begin
         bits_arr[nbits] <= sum_bit;
         nbits <= nbits + 1;
      end
      if (word_valid && nwords < 128) begin
         wword_arr[nwords]  <= sum_word;
         wcarry_arr[nwords] <= carry_out;
         wcyc_arr[nwords]   <= cyc;
         nwords <= nwords + 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic f, input logic a, input logic b);
      @(negedge clk);
      in_valid = v;
      in_first = f;
      a_bit    = a;
      b_bit    = b;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = 0; i < W; i++) drive(1'b1, (i == 0), a[i], b[i]);
   endtask

   // Checks the last completed word and the sum_bit stream since nb0.
   task automatic check_word(input string nm, input int nb0, input int nw0,
                             input logic [W-1:0] exp_sum, input logic exp_c);
      logic [W-1:0] got;
      chk({nm, "_nwords"}, nwords - nw0, 1);
      chk({nm, "_nbits"}, nbits - nb0, W);
      for (int j = 0; j < W; j++) got[j] = bits_arr[nb0 + j];
      chk({nm, "_stream"}, got, exp_sum);
      chk({nm, "_word"}, wword_arr[nwords - 1], exp_sum);
      chk({nm, "_carry"}, wcarry_arr[nwords - 1], exp_c);
   endtask

   initial begin
      vec_t vt[6];
      int   nb0;
      int   nw0;
      logic [W-1:0] ta;
      logic [W-1:0] tb;

      vt[0] = '{a: 8'h35, b: 8'h4A, exp_sum: 8'h7F, exp_c: 1'b0};
      vt[1] = '{a: 8'hFF, b: 8'h01, exp_sum: 8'h00, exp_c: 1'b1};
      vt[2] = '{a: 8'h01, b: 8'h01, exp_sum: 8'h02, exp_c: 1'b0};
      vt[3] = '{a: 8'hAA, b: 8'h55, exp_sum: 8'hFF, exp_c: 1'b0};
      vt[4] = '{a: 8'hFF, b: 8'hFF, exp_sum: 8'hFE, exp_c: 1'b1};
      vt[5] = '{a: 8'h6C, b: 8'hB3, exp_sum: 8'h1F, exp_c: 1'b1};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_first = 1'b0;
      a_bit    = 1'b0;
      b_bit    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub      = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_outs", {sum_bit, sum_bit_valid, carry_out, word_valid, busy}, 0);
      chk("rst_word", sum_word, 0);
      rst_n = 1'b1;
      idle(2);

      // 0x35 + 0x4A with per-beat latency and word_valid timing.
      nb0 = nbits; nw0 = nwords;
      ta = 8'h35; tb = 8'h4A;
      for (int i = 0; i < W; i++) begin
         drive(1'b1, (i == 0), ta[i], tb[i]);
         if (i > 0) begin
            chk("lat_sbv", sum_bit_valid, 1);
            chk("lat_busy", busy, 1);
         end
         if (i > 0 && i < W) chk("lat_wv_early", word_valid, 0);
      end
      idle(1);
      chk("lat_wv", word_valid, 1);
      chk("lat_word", sum_word, 8'h7F);
      chk("lat_busy_done", busy, 0);
      idle(1);
      chk("lat_wv_pulse", word_valid, 0);
      chk("lat_hold", sum_word, 8'h7F);
      idle(1);
      check_word("w35", nb0, nw0, 8'h7F, 1'b0);

      // Back-to-back words: second word_valid exactly W cycles later.
      nb0 = nbits; nw0 = nwords;
      send_word(8'hFF, 8'h01);
      send_word(8'h01, 8'h01);
      idle(3);
      chk("b2b_nwords", nwords - nw0, 2);
      chk("b2b_w1", {wcarry_arr[nw0], wword_arr[nw0]}, 9'h100);
      chk("b2b_w2", {wcarry_arr[nw0 + 1], wword_arr[nw0 + 1]}, 9'h002);
      chk("b2b_gap", wcyc_arr[nw0 + 1] - wcyc_arr[nw0], W);

      // Stall of 3 cycles after beat 4 of 0x0F + 0x01.
      nb0 = nbits; nw0 = nwords;
      ta = 8'h0F; tb = 8'h01;
      for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), ta[i], tb[i]);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1);
         if (k > 0) begin
            chk("stall_sbv", sum_bit_valid, 0);
            chk("stall_busy", busy, 1);
         end
      end
      for (int i = 4; i < W; i++) begin
         drive(1'b1, 1'b0, ta[i], tb[i]);
         if (i == 4) chk("stall_sbv_last", sum_bit_valid, 0);
      end
      idle(2);
      check_word("stall", nb0, nw0, 8'h10, 1'b0);

      // Restart at beat 5 with 0x80 + 0x80; the aborted word is dropped.
      nb0 = nbits; nw0 = nwords;
      ta = 8'h35; tb = 8'h4A;
      for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), ta[i], tb[i]);
      send_word(8'h80, 8'h80);
      idle(2);
      chk("restart_nwords", nwords - nw0, 1);
      chk("restart_nbits", nbits - nb0, 4 + W);
      chk("restart_word", {wcarry_arr[nwords - 1], wword_arr[nwords - 1]}, 9'h100);

      // Asynchronous reset in the middle of beat 3.
      ta = 8'h0F; tb = 8'h0F;
      for (int i = 0; i < 3; i++) drive(1'b1, (i == 0), ta[i], tb[i]);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outs", {sum_bit, sum_bit_valid, carry_out, word_valid, busy}, 0);
      chk("arst_word", sum_word, 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
      rst_n    = 1'b1;

      // Non-first beats in IDLE are ignored.
      nb0 = nbits; nw0 = nwords;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b1);
         chk("ign_sbv", sum_bit_valid, 0);
         chk("ign_busy", busy, 0);
      end
      idle(2);
      chk("ign_nbits", nbits - nb0, 0);
      chk("ign_nwords", nwords - nw0, 0);
      chk("ign_word", sum_word, 0);

      // Table-driven words, each followed by a short idle gap.
      for (int v = 0; v < 6; v++) begin
         nb0 = nbits; nw0 = nwords;
         send_word(vt[v].a, vt[v].b);
         idle(2);
         check_word($sformatf("vec%0d", v), nb0, nw0, vt[v].exp_sum, vt[v].exp_c);
      end

`ifdef SERIAL_ADDER_SUB_EN
      // Subtract mode: 0x10 - 0x01 and 0x01 - 0x02.
      nb0 = nbits; nw0 = nwords;
      sub = 1'b1;
      send_word(8'h10, 8'h01);
      sub = 1'b0;
      idle(2);
      check_word("sub_nob", nb0, nw0, 8'h0F, 1'b1);
      nb0 = nbits; nw0 = nwords;
      sub = 1'b1;
      send_word(8'h01, 8'h02);
      sub = 1'b0;
      idle(2);
      check_word("sub_borrow", nb0, nw0, 8'hFF, 1'b0);
      nb0 = nbits; nw0 = nwords;
      send_word(8'h10, 8'h01);
      idle(2);
      check_word("sub_off", nb0, nw0, 8'h11, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
